// File: rtl/kernel_dram_loader.sv
// DRAM-to-kernel-memory transfer engine: issues sequential DRAM word reads and
// unpacks each wide response into consecutive narrow kernel-memory write beats.
module kernel_dram_loader #(
  parameter int unsigned DRAM_DATA_BITS = 512,
  parameter int unsigned DRAM_ADDR_BITS = 29,
  parameter int unsigned KER_WIDTH      = 128,
  parameter int unsigned KER_ADDR_BITS  = 11,
  parameter int unsigned LEN_BITS       = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DRAM_ADDR_BITS-1:0] dram_base,
  input  logic [KER_ADDR_BITS-1:0]  ker_base,
  input  logic [LEN_BITS-1:0]       length,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [DRAM_ADDR_BITS-1:0] rd_req_addr,
  input  logic                      rd_rsp_valid,
  output logic                      rd_rsp_ready,
  input  logic [DRAM_DATA_BITS-1:0] rd_rsp_data,
  output logic                      ker_wr_en,
  output logic [KER_ADDR_BITS-1:0]  ker_wr_addr,
  output logic [KER_WIDTH-1:0]      ker_wr_data
);

  localparam int unsigned RATIO      = DRAM_DATA_BITS / KER_WIDTH;
  localparam int unsigned SLICE_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SLICE_BITS-1:0] LAST_SLICE = SLICE_BITS'(RATIO - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                    state_q;
  logic                      busy_q;
  logic                      done_q;
  logic [LEN_BITS-1:0]       len_q;
  logic [LEN_BITS-1:0]       req_cnt_q;
  logic [LEN_BITS-1:0]       rsp_cnt_q;
  logic                      req_valid_q;
  logic [DRAM_ADDR_BITS-1:0] req_addr_q;
  logic [DRAM_DATA_BITS-1:0] buf_q;
  logic [SLICE_BITS-1:0]     slice_q;
  logic                      wr_en_q;
  logic [KER_ADDR_BITS-1:0]  wr_addr_q;
  logic [KER_ADDR_BITS-1:0]  wr_ptr_q;
  logic [KER_WIDTH-1:0]      wr_data_q;

  logic                  req_fire_c;
  logic                  last_slice_c;
  logic                  last_beat_c;
  logic                  rsp_ready_c;
  logic                  rsp_fire_c;
  logic [SLICE_BITS-1:0] slice_nxt_c;

  // The buffer holds a word exactly while its beats are being written, so
  // "buffer empty" is simply "no beat in flight".
  always_comb begin
    req_fire_c   = req_valid_q && rd_req_ready;
    last_slice_c = wr_en_q && (slice_q == LAST_SLICE);
    last_beat_c  = last_slice_c && (rsp_cnt_q == len_q);
    rsp_ready_c  = (state_q == S_RUN) && (!wr_en_q || last_slice_c);
    rsp_fire_c   = rsp_ready_c && rd_rsp_valid;
    slice_nxt_c  = slice_q + SLICE_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      buf_q       <= '0;
      slice_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_ptr_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (length != '0) begin
              state_q     <= S_RUN;
              len_q       <= length;
              req_cnt_q   <= '0;
              rsp_cnt_q   <= '0;
              req_valid_q <= 1'b1;
              req_addr_q  <= dram_base;
              wr_ptr_q    <= ker_base;
              slice_q     <= '0;
              wr_en_q     <= 1'b0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Request channel runs ahead of responses; valid/addr only move on a handshake.
          if (req_fire_c) begin
            req_cnt_q   <= req_cnt_q + LEN_BITS'(1);
            req_addr_q  <= req_addr_q + DRAM_ADDR_BITS'(1);
            req_valid_q <= (req_cnt_q + LEN_BITS'(1)) != len_q;
          end
          if (last_beat_c) begin
            wr_en_q <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (rsp_fire_c) begin
            buf_q     <= rd_rsp_data;
            wr_en_q   <= 1'b1;
            slice_q   <= '0;
            wr_data_q <= rd_rsp_data[KER_WIDTH-1:0];
            wr_addr_q <= wr_ptr_q;
            wr_ptr_q  <= wr_ptr_q + KER_ADDR_BITS'(1);
            rsp_cnt_q <= rsp_cnt_q + LEN_BITS'(1);
          end else if (last_slice_c) begin
            wr_en_q <= 1'b0;
          end else if (wr_en_q) begin
            slice_q   <= slice_nxt_c;
            wr_data_q <= buf_q[int'(slice_nxt_c) * KER_WIDTH +: KER_WIDTH];
            wr_addr_q <= wr_ptr_q;
            wr_ptr_q  <= wr_ptr_q + KER_ADDR_BITS'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = req_addr_q;
  assign rd_rsp_ready = rsp_ready_c;
  assign ker_wr_en    = wr_en_q;
  assign ker_wr_addr  = wr_addr_q;
  assign ker_wr_data  = wr_data_q;

endmodule

// File: tb/tb_kernel_dram_loader.sv
// Bench for kernel_dram_loader: a DRAM responder model plus a scoreboard that
// predicts every request, write beat (timing, address, data) and done pulse.
module tb_kernel_dram_loader;

  localparam int unsigned DB  = 512;
  localparam int unsigned AB  = 29;
  localparam int unsigned KW  = 128;
  localparam int unsigned KAB = 11;
  localparam int unsigned LB  = 10;
  localparam int unsigned R   = DB / KW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AB-1:0] dram_base = '0;
  logic [KAB-1:0] ker_base = '0;
  logic [LB-1:0] length = '0;
  logic          busy, done;
  logic          rd_req_valid, rd_req_ready = 1'b0;
  logic [AB-1:0] rd_req_addr;
  logic          rd_rsp_valid = 1'b0, rd_rsp_ready;
  logic [DB-1:0] rd_rsp_data = '0;
  logic          ker_wr_en;
  logic [KAB-1:0] ker_wr_addr;
  logic [KW-1:0] ker_wr_data;

  kernel_dram_loader dut (
    .clk(clk), .rst(rst), .start(start), .dram_base(dram_base), .ker_base(ker_base),
    .length(length), .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .ker_wr_en(ker_wr_en), .ker_wr_addr(ker_wr_addr), .ker_wr_data(ker_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    int            rdy;
  } pend_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pend_t          pend_q[$];
  logic [KAB-1:0] exp_addr_q[$];
  logic [KW-1:0]  exp_data_q[$];
  int             due_q[$];
  logic [KAB-1:0] log_addr[$];
  logic [KW-1:0]  log_data[$];
  logic [AB-1:0]  log_req[$];

  logic [AB-1:0]  m_base;
  logic [KAB-1:0] m_kptr;
  int  m_len = 0, m_req_idx = 0, m_wr_cnt = 0, first_wr = -1, last_wr = -1;
  int  done_cnt = 0, req_valid_seen = 0, max_lat = 15, mlat;
  bit  rand_mode = 1'b0, fixed_en = 1'b0, prev_rv = 1'b0, prev_hs = 1'b0, prev_done = 1'b0;
  logic [AB-1:0] prev_ra;
  logic [DB-1:0] fixed_word, mw;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DB-1:0] rand_word();
    logic [DB-1:0] w;
    for (int i = 0; i < int'(DB / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // DRAM responder and per-cycle scoreboard; inputs change here, on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_req_ready = 1'b0;
      rd_rsp_valid = 1'b0;
      prev_rv      = 1'b0;
      prev_hs      = 1'b0;
      prev_done    = 1'b0;
    end else begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        check(ker_wr_en == 1'b1, "wr_en_due", 128'(ker_wr_en), 128'(1));
        if (ker_wr_en && exp_addr_q.size() > 0) begin
          check(ker_wr_addr == exp_addr_q[0], "wr_addr", 128'(ker_wr_addr), 128'(exp_addr_q[0]));
          check(ker_wr_data == exp_data_q[0], "wr_data", ker_wr_data, exp_data_q[0]);
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
          log_addr.push_back(ker_wr_addr);
          log_data.push_back(ker_wr_data);
          m_wr_cnt++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
      end else begin
        check(ker_wr_en == 1'b0, "wr_en_spurious", 128'(ker_wr_en), 128'(0));
      end

      if (prev_done) begin
        check(done == 1'b0, "done_one_cycle", 128'(done), 128'(0));
        check(busy == 1'b0, "busy_falls", 128'(busy), 128'(0));
      end
      if (done) begin
        done_cnt++;
        check(busy == 1'b1, "busy_with_done", 128'(busy), 128'(1));
        if (m_len > 0) begin
          check(last_wr == cyc - 1, "done_timing", 128'(cyc), 128'(last_wr + 1));
          check(exp_addr_q.size() == 0, "done_beats_left", 128'(exp_addr_q.size()), 128'(0));
        end
      end
      prev_done = done;

      if (prev_rv && !prev_hs) begin
        check(rd_req_valid == 1'b1, "req_valid_held", 128'(rd_req_valid), 128'(1));
        check(rd_req_addr == prev_ra, "req_addr_held", 128'(rd_req_addr), 128'(prev_ra));
      end
      if (rd_req_valid) req_valid_seen++;

      rd_req_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      prev_hs = rd_req_valid && rd_req_ready;
      prev_rv = rd_req_valid;
      prev_ra = rd_req_addr;
      if (prev_hs) begin
        check(m_req_idx < m_len, "req_extra", 128'(m_req_idx), 128'(m_len));
        check(rd_req_addr == AB'(m_base + AB'(m_req_idx)), "req_addr",
              128'(rd_req_addr), 128'(AB'(m_base + AB'(m_req_idx))));
        mw   = fixed_en ? fixed_word : rand_word();
        mlat = rand_mode ? $urandom_range(1, max_lat) : 1;
        pend_q.push_back('{data: mw, rdy: cyc + mlat});
        for (int k = 0; k < int'(R); k++) begin
          exp_addr_q.push_back(m_kptr);
          exp_data_q.push_back(mw[k*KW +: KW]);
          m_kptr = m_kptr + KAB'(1);
        end
        log_req.push_back(rd_req_addr);
        m_req_idx++;
      end

      rd_rsp_valid = (pend_q.size() > 0) && (pend_q[0].rdy <= cyc) &&
                     (!rand_mode || $urandom_range(0, 3) != 0);
      rd_rsp_data  = rd_rsp_valid ? pend_q[0].data : '0;
      if (rd_rsp_valid && rd_rsp_ready) begin
        void'(pend_q.pop_front());
        for (int k = 1; k <= int'(R); k++) due_q.push_back(cyc + k);
      end
    end
  end

  task automatic start_xfer(input logic [AB-1:0] db, input logic [KAB-1:0] kb,
                            input int len, input bit rmode);
    @(negedge clk);
    rand_mode = rmode;
    m_base = db; m_kptr = kb; m_len = len; m_req_idx = 0; m_wr_cnt = 0;
    first_wr = -1; last_wr = -1; req_valid_seen = 0;
    log_addr.delete(); log_data.delete(); log_req.delete();
    dram_base = db; ker_base = kb; length = LB'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(busy == 1'b1, "busy_after_start", 128'(busy), 128'(1));
    if (len > 0) begin
      check(rd_req_valid == 1'b1, "first_req_valid", 128'(rd_req_valid), 128'(1));
      check(rd_req_addr == db, "first_req_addr", 128'(rd_req_addr), 128'(db));
    end else begin
      check(done == 1'b1, "len0_done", 128'(done), 128'(1));
    end
  endtask

  task automatic wait_xfer(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(done_cnt == d0 + 1, "done_count", 128'(done_cnt - d0), 128'(1));
    repeat (3) @(negedge clk);
    check(done_cnt == d0 + 1, "done_once", 128'(done_cnt - d0), 128'(1));
    check(m_req_idx == m_len, "req_total", 128'(m_req_idx), 128'(m_len));
    check(m_wr_cnt == m_len * int'(R), "wr_total", 128'(m_wr_cnt), 128'(m_len * int'(R)));
  endtask

  task automatic run_xfer(input logic [AB-1:0] db, input logic [KAB-1:0] kb,
                          input int len, input bit rmode);
    int d0;
    d0 = done_cnt;
    start_xfer(db, kb, len, rmode);
    wait_xfer(d0, 8000);
  endtask

  task automatic check_all_zero(input string tag);
    check({busy, done, rd_req_valid, rd_rsp_ready, ker_wr_en} == 5'b0, tag,
          128'({busy, done, rd_req_valid, rd_rsp_ready, ker_wr_en}), 128'(0));
    check(rd_req_addr == '0 && ker_wr_addr == '0 && ker_wr_data == '0, {tag, "_buses"},
          128'(ker_wr_data | 128'(rd_req_addr) | 128'(ker_wr_addr)), 128'(0));
  endtask

  localparam logic [KW-1:0] SA = 128'hA0A0_0001_1111_2222_3333_4444_5555_AAAA;
  localparam logic [KW-1:0] SB = 128'hB0B0_0002_6666_7777_8888_9999_0000_BBBB;
  localparam logic [KW-1:0] SC = 128'hC0C0_0003_1234_5678_9ABC_DEF0_1357_CCCC;
  localparam logic [KW-1:0] SD = 128'hD0D0_0004_2468_ACE0_FDB9_7531_0246_DDDD;

  initial begin
    int d0;
    logic [KW-1:0] exp_sl [4];
    exp_sl[0] = SA; exp_sl[1] = SB; exp_sl[2] = SC; exp_sl[3] = SD;

    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    // Single word with known slices.
    fixed_en = 1'b1;
    fixed_word = {SD, SC, SB, SA};
    run_xfer(AB'(32'h10), KAB'(0), 1, 1'b0);
    fixed_en = 1'b0;
    check(log_req.size() == 1 && log_req[0] == AB'(32'h10), "t1_req_addr",
          128'(log_req.size() > 0 ? log_req[0] : '0), 128'(32'h10));
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check(log_addr[i] == KAB'(i), "t1_wr_addr", 128'(log_addr[i]), 128'(i));
      check(log_data[i] == exp_sl[i], "t1_wr_data", log_data[i], exp_sl[i]);
    end
    check(last_wr - first_wr == 3, "t1_contiguous", 128'(last_wr - first_wr), 128'(3));

    // Long fully-streaming transfer.
    run_xfer(AB'(32'h1FFF_FF00), KAB'(0), 480, 1'b0);
    check(last_wr - first_wr == 1919, "stream_no_gaps", 128'(last_wr - first_wr), 128'(1919));
    check(log_addr.size() == 1920 && log_addr[1919] == KAB'(1919), "stream_last_addr",
          128'(log_addr.size() > 0 ? log_addr[log_addr.size()-1] : '0), 128'(1919));
    check(log_req.size() == 480 && log_req[479] == AB'(32'h1FFF_FF00 + 479), "stream_last_req",
          128'(log_req.size() > 0 ? log_req[log_req.size()-1] : '0),
          128'(AB'(32'h1FFF_FF00 + 479)));

    // Random back-pressure and long response latency.
    max_lat = 15;
    run_xfer(AB'($urandom), KAB'($urandom), 64, 1'b1);

    // Zero length: done only, no traffic.
    run_xfer(AB'(32'h55), KAB'(7), 0, 1'b0);
    check(req_valid_seen == 0, "len0_no_req", 128'(req_valid_seen), 128'(0));

    // Kernel address wrap.
    run_xfer(AB'(32'h200), KAB'(2046), 1, 1'b0);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      check(log_addr[i] == KAB'(2046 + i), "wrap_addr", 128'(log_addr[i]), 128'(KAB'(2046 + i)));

    // Start while busy is ignored.
    d0 = done_cnt;
    start_xfer(AB'(32'h300), KAB'(100), 16, 1'b1);
    repeat (20) @(negedge clk);
    dram_base = AB'(32'h7777); ker_base = KAB'(5); length = LB'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_xfer(d0, 8000);

    // Reset mid-transfer, then a fresh transfer.
    start_xfer(AB'(32'h400), KAB'(0), 64, 1'b1);
    repeat (60) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2;
    check_all_zero("mid_reset");
    rst = 1'b0;
    pend_q.delete(); exp_addr_q.delete(); exp_data_q.delete(); due_q.delete();
    m_len = 0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check(done_cnt == d0, "no_done_after_reset", 128'(done_cnt - d0), 128'(0));
    run_xfer(AB'($urandom), KAB'($urandom), 8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_dram_loader.md
# kernel_dram_loader

Transfer engine that fills kernel memory from external DRAM. On a start command it issues sequential read requests to the DRAM controller, accepts the 512-bit read responses in order, and unpacks each one into consecutive 128-bit kernel-memory write beats. It sits between the DRAM controller's read port and the kernel memory write port, and is driven by the instruction-level controller.

## Interface
Parameters:
- DRAM_DATA_BITS, 512, DRAM read data width.
- DRAM_ADDR_BITS, 29, DRAM word address width.
- KER_WIDTH, 128, kernel memory word width; DRAM_DATA_BITS must be an integer multiple of it. Ratio R = DRAM_DATA_BITS/KER_WIDTH (4 by default).
- KER_ADDR_BITS, 11, kernel memory address width.
- LEN_BITS, 10, width of the transfer length in DRAM words.

Ports:
- clk  in  1  clock; the block has one clock and its reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- dram_base  in  DRAM_ADDR_BITS  first DRAM word address.
- ker_base  in  KER_ADDR_BITS  first kernel write address.
- length  in  LEN_BITS  number of DRAM words to transfer.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rd_req_valid  out  1  / rd_req_ready  in  1  / rd_req_addr  out  DRAM_ADDR_BITS  DRAM read request channel.
- rd_rsp_valid  in  1  / rd_rsp_ready  out  1  / rd_rsp_data  in  DRAM_DATA_BITS  DRAM read response channel; responses arrive in request order.
- ker_wr_en  out  1  / ker_wr_addr  out  KER_ADDR_BITS  / ker_wr_data  out  KER_WIDTH  kernel memory write port.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE with start=1 and length>0: latch dram_base, ker_base and length, clear all counters, go to RUN.
  - IDLE with start=1 and length=0: go directly to DONE.
  - RUN: go to DONE on the cycle the last write beat is issued.
  - DONE: drive done=1 for one cycle, then return to IDLE.
- start outside IDLE is ignored.
- Request side, in RUN:
  - rd_req_valid=1 while req_cnt < length.
  - rd_req_addr = dram_base + req_cnt.
  - req_cnt increments on valid&&ready.
  - Requests are issued independently of responses and need no outstanding limit; the controller is flow-controlled by rd_rsp_ready.
  - Once asserted, rd_req_valid and rd_req_addr stay stable until the handshake completes.
- Response side: a one-word buffer plus a slice counter (0..R-1).
  - rd_rsp_ready = RUN && (buffer empty || (ker_wr_en && slice==R-1)).
  - Slice k = rd_rsp_data[k*KER_WIDTH +: KER_WIDTH], least-significant slice first.
- Write side:
  - ker_wr_addr starts at ker_base and increments by one per beat, modulo 2^KER_ADDR_BITS (wraps silently).
  - Total beats = length*R.
- Address arithmetic: DRAM address addition also wraps modulo 2^DRAM_ADDR_BITS.
- Reset values: every output is 0; state is IDLE; counters and buffer are cleared.
- Reset mid-transfer: abort immediately with no done pulse. The DRAM controller is reset together with this block, so in-flight responses are discarded.
- rd_rsp_ready=0 in IDLE and DONE.

## Timing
- rd_req_valid first asserts the cycle after start is accepted.
- Response accepted in cycle t: ker_wr_en=1 in cycles t+1 … t+R carrying slices 0 … R-1. All write outputs are registered.
- The next response can be accepted in cycle t+R, so a continuously valid DRAM stream produces one write beat per cycle with no gaps.
- done=1 the cycle after the final write beat. busy falls the cycle after done.
- length=0: done=1 the cycle after start; there are no requests and no writes.

## Test plan
- length=1, dram_base=0x10, ker_base=0, response slices A,B,C,D (LSB first) -> one request at addr 0x10, then writes addr 0..3 with data A..D on consecutive cycles; done pulses once, the cycle after the addr-3 write.
- length=480, ready and valid always high -> 480 requests at addresses base..base+479; 1920 contiguous write beats at addr 0..1919 with no gaps after the first; exactly one done pulse.
- length=64 with random rd_req_ready and rd_rsp_valid (including response latency greater than 10 cycles) -> requests in order with held address/valid; 256 writes with correct data and addresses, none dropped or duplicated.
- length=0 -> done the cycle after start; rd_req_valid and ker_wr_en never asserted.
- ker_base=2046, length=1 -> write addresses 2046, 2047, 0, 1.
- start pulsed while busy -> ignored. rst asserted mid-transfer -> all outputs 0 the next cycle and no done pulse; a fresh start then completes normally.
